piece_sequencer: RTL and testbench

Sequences the `generate_tetromino` block and owns the hold slot. Sits between the game FSM and the generator:
- warms the generator after reset;
- turns spawn/hold requests into `enable` pulses;
- captures the generator's current piece;
- presents every new falling piece to the game FSM as a registered one-cycle `spawn_valid` strobe with a normalized spawn pose.

---
 rtl/piece_sequencer.sv | 101 ++++++++++
 tb/tb_piece_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/piece_sequencer.sv
// piece_sequencer: drives the tetromino generator, owns the hold slot and emits
// each new falling piece as a one-cycle spawn strobe in the fixed spawn pose.
package global_pkg;
   typedef struct packed {
      logic [4:0] x;
      logic [4:0] y;
   } coord_t;
   typedef struct packed {
      logic [2:0]  idx;
      logic [15:0] tetromino;
      logic [1:0]  rotation;
      coord_t      coordinate;
   } tetromino_ctrl;
   localparam logic [2:0] TETROMINO_EMPTY = 3'd7;
endpackage

module piece_sequencer
   import global_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          spawn_req,
   input  logic          hold_req,
   input  tetromino_ctrl active_in,
   input  tetromino_ctrl gen_t_out,
   input  tetromino_ctrl gen_t_next,
   output logic          gen_enable,
   output logic          ready,
   output logic          spawn_valid,
   output tetromino_ctrl spawn_piece,
   output tetromino_ctrl next_preview,
   output logic          preview_valid,
   output tetromino_ctrl hold_piece,
   output logic          hold_valid,
   output logic          hold_used
);
   typedef enum logic [2:0] {WARM, IDLE, GEN, CAPTURE, EMIT} state_t;

   localparam tetromino_ctrl EMPTY_PIECE = '{idx: TETROMINO_EMPTY, tetromino: 16'd0, rotation: 2'd0,
                                             coordinate: '{x: 5'd3, y: 5'd0}};

   state_t        r_state, w_next;
   tetromino_ctrl r_spawn, r_hold;
   logic          r_preview, r_hold_valid, r_hold_used;
   logic          w_spawn_acc, w_hold_acc;

   function automatic tetromino_ctrl normalize(input tetromino_ctrl p);
      tetromino_ctrl n;
      n = p;
      n.rotation = 2'd0;
      n.coordinate = '{x: 5'd3, y: 5'd0};
      return n;
   endfunction

   always_comb begin
      w_spawn_acc = (r_state == IDLE) && spawn_req;
      // a simultaneous spawn_req wins; the hold is simply dropped
      w_hold_acc  = (r_state == IDLE) && !spawn_req && hold_req && !r_hold_used;
      w_next      = r_state;
      unique case (r_state)
         WARM:    w_next = IDLE;
         IDLE:    w_next = w_spawn_acc ? GEN : w_hold_acc ? (r_hold_valid ? EMIT : GEN) : IDLE;
         GEN:     w_next = CAPTURE;
         CAPTURE: w_next = EMIT;
         EMIT:    w_next = IDLE;
         default: w_next = WARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= WARM;
         r_spawn      <= EMPTY_PIECE;
         r_hold       <= EMPTY_PIECE;
         r_preview    <= 1'b0;
         r_hold_valid <= 1'b0;
         r_hold_used  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == WARM) r_preview <= 1'b1;
         if (w_spawn_acc) r_hold_used <= 1'b0;
         if (w_hold_acc) begin
            r_hold       <= normalize(active_in);
            r_hold_valid <= 1'b1;
            r_hold_used  <= 1'b1;
            if (r_hold_valid) r_spawn <= r_hold;
         end
         if (r_state == CAPTURE) r_spawn <= normalize(gen_t_out);
      end
   end

   assign gen_enable    = (r_state == WARM || r_state == GEN) && !rst;
   assign ready         = r_state == IDLE;
   assign spawn_valid   = r_state == EMIT;
   assign spawn_piece   = r_spawn;
   assign next_preview  = gen_t_next;
   assign preview_valid = r_preview;
   assign hold_piece    = r_hold;
   assign hold_valid    = r_hold_valid;
   assign hold_used     = r_hold_used;
endmodule

// File: tb/tb_piece_sequencer.sv
// tb_piece_sequencer: directed vector table followed by randomized traffic,
// both checked against a latency-based reference model of the sequencer.
module tb_piece_sequencer;
   import global_pkg::*;

   logic          clk = 1'b0;
   logic          rst, spawn_req, hold_req;
   tetromino_ctrl active_in, gen_t_out, gen_t_next;
   logic          gen_enable, ready, spawn_valid, preview_valid, hold_valid, hold_used;
   tetromino_ctrl spawn_piece, next_preview, hold_piece;

   piece_sequencer dut (
      .clk(clk), .rst(rst), .spawn_req(spawn_req), .hold_req(hold_req),
      .active_in(active_in), .gen_t_out(gen_t_out), .gen_t_next(gen_t_next),
      .gen_enable(gen_enable), .ready(ready), .spawn_valid(spawn_valid),
      .spawn_piece(spawn_piece), .next_preview(next_preview), .preview_valid(preview_valid),
      .hold_piece(hold_piece), .hold_valid(hold_valid), .hold_used(hold_used)
   );

   always #5 clk = ~clk;

   int  n_pass = 0;
   int  n_total = 0;
   bit  fixed_gen = 1'b1;

   function automatic tetromino_ctrl rand_piece(input bit fixed);
      tetromino_ctrl p;
      p.idx          = fixed ? 3'd5 : 3'($urandom_range(0, 6));
      p.tetromino    = 16'($urandom);
      p.rotation     = 2'($urandom);
      p.coordinate.x = 5'($urandom);
      p.coordinate.y = 5'($urandom);
      return p;
   endfunction

   function automatic tetromino_ctrl norm(input tetromino_ctrl p);
      tetromino_ctrl n;
      n = p;
      n.rotation = 2'd0;
      n.coordinate.x = 5'd3;
      n.coordinate.y = 5'd0;
      return n;
   endfunction

   // generator stand-in: advances current <- next on every enable pulse
   always @(posedge clk)
      if (gen_enable) begin
         gen_t_out  <= gen_t_next;
         gen_t_next <= rand_piece(fixed_gen);
      end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // reference model: a request accepted in IDLE starts a fixed-latency job
   bit            m_warm, m_swap, m_prev, m_hv, m_hu;
   int            m_t;
   tetromino_ctrl m_sp, m_hd, empty_p;

   task automatic model_reset();
      m_warm = 1'b1; m_swap = 1'b0; m_prev = 1'b0; m_hv = 1'b0; m_hu = 1'b0; m_t = 0;
      m_sp = empty_p; m_hd = empty_p;
   endtask

   task automatic model_check();
      int lat;
      lat = m_swap ? 1 : 3;
      chk("ready", 64'(ready), 64'(!m_warm && m_t == 0));
      chk("spawn_valid", 64'(spawn_valid), 64'(m_t != 0 && m_t == lat));
      chk("gen_enable", 64'(gen_enable), 64'(!rst && (m_warm || (m_t == 1 && !m_swap))));
      chk("preview_valid", 64'(preview_valid), 64'(m_prev));
      chk("hold_valid", 64'(hold_valid), 64'(m_hv));
      chk("hold_used", 64'(hold_used), 64'(m_hu));
      chk("spawn_piece", 64'(spawn_piece), 64'(m_sp));
      chk("hold_piece", 64'(hold_piece), 64'(m_hd));
      chk("next_preview", 64'(next_preview), 64'(gen_t_next));
   endtask

   task automatic model_step();
      if (rst) model_reset();
      else if (m_warm) begin
         m_warm = 1'b0;
         m_prev = 1'b1;
      end else if (m_t == 0) begin
         if (spawn_req) begin
            m_hu = 1'b0; m_swap = 1'b0; m_t = 1;
         end else if (hold_req && !m_hu) begin
            m_swap = m_hv;
            if (m_hv) m_sp = m_hd;
            m_hd = norm(active_in);
            m_hv = 1'b1; m_hu = 1'b1; m_t = 1;
         end
      end else begin
         if (!m_swap && m_t == 2) m_sp = norm(gen_t_out);
         m_t = (m_t == (m_swap ? 1 : 3)) ? 0 : m_t + 1;
      end
   endtask

   typedef struct {
      bit r, s, h;
      logic [2:0] a;
      bit rdy, sv, ge;
      logic [2:0] sp;
      bit hv, hu;
      logic [2:0] hd;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(input int r, s, h, a, rdy, sv, ge, sp, hv, hu, hd);
      vec_t v;
      v.r = r[0]; v.s = s[0]; v.h = h[0]; v.a = a[2:0];
      v.rdy = rdy[0]; v.sv = sv[0]; v.ge = ge[0]; v.sp = sp[2:0];
      v.hv = hv[0]; v.hu = hu[0]; v.hd = hd[2:0];
      return v;
   endfunction

   initial begin
      empty_p = '{idx: TETROMINO_EMPTY, tetromino: 16'd0, rotation: 2'd0, coordinate: '{x: 5'd3, y: 5'd0}};
      //            r s h a  rdy sv ge sp hv hu hd
      tbl[0]  = mk(1,0,0,0, 0,0,0,7, 0,0,7);
      tbl[1]  = mk(0,0,0,0, 0,0,1,7, 0,0,7);
      tbl[2]  = mk(0,1,0,0, 1,0,0,7, 0,0,7);
      tbl[3]  = mk(0,0,1,2, 0,0,1,7, 0,0,7);
      tbl[4]  = mk(0,0,0,0, 0,0,0,7, 0,0,7);
      tbl[5]  = mk(0,0,0,0, 0,1,0,5, 0,0,7);
      tbl[6]  = mk(0,0,1,2, 1,0,0,5, 0,0,7);
      tbl[7]  = mk(0,0,1,3, 0,0,1,5, 1,1,2);
      tbl[8]  = mk(0,0,0,0, 0,0,0,5, 1,1,2);
      tbl[9]  = mk(0,0,0,0, 0,1,0,5, 1,1,2);
      tbl[10] = mk(0,0,1,6, 1,0,0,5, 1,1,2);
      tbl[11] = mk(0,1,1,6, 1,0,0,5, 1,1,2);
      tbl[12] = mk(0,0,0,0, 0,0,1,5, 1,0,2);
      tbl[13] = mk(0,0,0,0, 0,0,0,5, 1,0,2);
      tbl[14] = mk(0,0,0,0, 0,1,0,5, 1,0,2);
      tbl[15] = mk(0,0,1,6, 1,0,0,5, 1,0,2);
      tbl[16] = mk(0,0,0,0, 0,1,0,2, 1,1,6);
      tbl[17] = mk(0,1,0,0, 1,0,0,2, 1,1,6);
      tbl[18] = mk(0,0,0,0, 0,0,1,2, 1,0,6);
      tbl[19] = mk(1,0,0,0, 0,0,0,2, 1,0,6);
      tbl[20] = mk(0,0,0,0, 0,0,1,7, 0,0,7);
      tbl[21] = mk(0,0,0,0, 1,0,0,7, 0,0,7);

      rst = 1'b1; spawn_req = 1'b0; hold_req = 1'b0;
      active_in = empty_p;
      gen_t_next = rand_piece(1'b1);
      gen_t_out = empty_p;
      repeat (2) @(posedge clk);
      model_reset();

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].r; spawn_req = tbl[i].s; hold_req = tbl[i].h;
         active_in = '{idx: tbl[i].a, tetromino: 16'hA5C3, rotation: 2'd3, coordinate: '{x: 5'd7, y: 5'd12}};
         #1;
         chk("vec_ready", 64'(ready), 64'(tbl[i].rdy));
         chk("vec_spawn_valid", 64'(spawn_valid), 64'(tbl[i].sv));
         chk("vec_gen_enable", 64'(gen_enable), 64'(tbl[i].ge));
         chk("vec_spawn_idx", 64'(spawn_piece.idx), 64'(tbl[i].sp));
         chk("vec_hold_valid", 64'(hold_valid), 64'(tbl[i].hv));
         chk("vec_hold_used", 64'(hold_used), 64'(tbl[i].hu));
         chk("vec_hold_idx", 64'(hold_piece.idx), 64'(tbl[i].hd));
         chk("vec_hold_pose", 64'({hold_piece.rotation, hold_piece.coordinate}), 64'({2'd0, 5'd3, 5'd0}));
         chk("vec_spawn_pose", 64'({spawn_piece.rotation, spawn_piece.coordinate}), 64'({2'd0, 5'd3, 5'd0}));
         model_check();
         model_step();
      end

      fixed_gen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) == 0);
         spawn_req = ($urandom_range(0, 3) == 0);
         hold_req = ($urandom_range(0, 2) == 0);
         active_in = rand_piece(1'b0);
         #1;
         model_check();
         model_step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
